dds_pulse_burst_mc: RTL and testbench

//  Multi-channel DDS pulse-burst generator and next-generation pulse source for the IRE control board.
//  One shared 32-bit phase accumulator drives NCH channels, each with its own phase offset, pulse width and pulse count.
//  Per channel, emits rectangular pulses as DAC codes with DAC clocks.

---
 rtl/dds_pulse_burst_mc.sv | 139 +++++++++++++
 tb/tb_dds_pulse_burst_mc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_pulse_burst_mc.sv
// Multi-channel DDS pulse-burst generator: one shared phase accumulator, per-channel
// phase offset, pulse width and pulse count, registered DAC codes with inverted-clock DAC clocks.
module dds_pulse_burst_mc #(
  parameter int                NCH     = 2,
  parameter int                ACC_W   = 32,
  parameter int                PH_W    = 16,
  parameter int                DATA_W  = 14,
  parameter int                CNT_W   = 16,
  parameter logic [DATA_W-1:0] DATA_HI = 14'h3FFF,
  parameter logic [DATA_W-1:0] DATA_LO = 14'h2000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    EN,
  input  logic                    Stop,
  input  logic                    Mode,
  input  logic [ACC_W-1:0]        Fword,
  input  logic [NCH*PH_W-1:0]     Pword,
  input  logic [NCH*PH_W-1:0]     Pwidth,
  input  logic [NCH*CNT_W-1:0]    Num,
  output logic                    Busy,
  output logic                    Done,
  output logic [NCH-1:0]          DA_Clk,
  output logic [NCH*DATA_W-1:0]   DA_Data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]            state_q;
  logic [ACC_W-1:0]      acc_q, fword_q;
  logic [NCH*PH_W-1:0]   pword_q, pwidth_q, p_prev_q;
  logic [NCH*CNT_W-1:0]  num_q, cnt_q, cnt_d;
  logic                  mode_q, first_q, done_q;
  logic [NCH-1:0]        in_prev_q, chdone_q, chdone_d;
  logic [NCH*DATA_W-1:0] da_q, da_d;

  logic [PH_W-1:0]       p_w [NCH];
  logic [NCH*PH_W-1:0]   p_d;
  logic [NCH-1:0]        in_w, wrap_w, start_w, pend_w, full_w, degen_w;

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    in_w     = '0;
    wrap_w   = '0;
    start_w  = '0;
    pend_w   = '0;
    full_w   = '0;
    degen_w  = '0;
    chdone_d = chdone_q;
    cnt_d    = cnt_q;
    p_d      = '0;
    da_d     = {NCH{DATA_LO}};
    for (int i = 0; i < NCH; i++) begin
      p_w[i]   = acc_q[ACC_W-1 -: PH_W] + pword_q[i*PH_W +: PH_W];
      p_d[i*PH_W +: PH_W] = p_w[i];
      in_w[i]  = p_w[i] < pwidth_q[i*PH_W +: PH_W];
      // A smaller phase than last cycle means the channel phase carried out.
      wrap_w[i] = !first_q && (p_w[i] < p_prev_q[i*PH_W +: PH_W]);
      full_w[i] = !mode_q && (cnt_q[i*CNT_W +: CNT_W] == num_q[i*CNT_W +: CNT_W]);
      pend_w[i] = in_prev_q[i] && (!in_w[i] || wrap_w[i]);
      start_w[i] = in_w[i] && (first_q || !in_prev_q[i] || wrap_w[i])
                   && !chdone_q[i] && !full_w[i];
      chdone_d[i] = chdone_q[i] || (full_w[i] && pend_w[i]);
      cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(start_w[i]);
      if (in_w[i] && !chdone_d[i]) da_d[i*DATA_W +: DATA_W] = DATA_HI;
      degen_w[i] = !Mode && ((Num[i*CNT_W +: CNT_W] == '0) || (Pwidth[i*PH_W +: PH_W] == '0));
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge Clk) begin
    // NOTE: every register, per-channel state included, is reset so a mid-run Rst leaves nothing stale.
    if (Rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      fword_q   <= '0;
      pword_q   <= '0;
      pwidth_q  <= '0;
      p_prev_q  <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      first_q   <= 1'b0;
      done_q    <= 1'b0;
      in_prev_q <= '0;
      chdone_q  <= '0;
      da_q      <= {NCH{DATA_LO}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (EN && !Stop) begin
            fword_q   <= Fword;
            pword_q   <= Pword;
            pwidth_q  <= Pwidth;
            num_q     <= Num;
            mode_q    <= Mode;
            acc_q     <= '0;
            first_q   <= 1'b1;
            in_prev_q <= '0;
            p_prev_q  <= '0;
            cnt_q     <= '0;
            chdone_q  <= degen_w;
            state_q   <= (&degen_w) ? S_FLUSH : S_RUN;
          end
        end
        S_RUN: begin
          acc_q     <= acc_q + fword_q;
          first_q   <= 1'b0;
          in_prev_q <= in_w;
          p_prev_q  <= p_d;
          cnt_q     <= cnt_d;
          chdone_q  <= chdone_d;
          if (Stop) begin
            da_q    <= {NCH{DATA_LO}};
            state_q <= S_IDLE;
          end else begin
            da_q <= da_d;
            if (!mode_q && (&chdone_d)) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          da_q    <= {NCH{DATA_LO}};
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;
  assign DA_Data = da_q;
  assign DA_Clk  = {NCH{~Clk}};

endmodule

// File: tb/tb_dds_pulse_burst_mc.sv
// Scoreboard bench for dds_pulse_burst_mc: expected Busy/Done/DA codes come from a
// closed-form pulse-index model, are queued per cycle and compared on the falling edge.
module tb_dds_pulse_burst_mc;
  localparam int NCH = 2, ACC_W = 32, PH_W = 16, DATA_W = 14, CNT_W = 16;
  localparam logic [DATA_W-1:0] HI = 14'h3FFF, LO = 14'h2000;
  localparam int NEVER = 1 << 20;

  logic                  Clk = 1'b0, Rst = 1'b1, EN = 1'b0, Stop = 1'b0, Mode = 1'b0;
  logic [ACC_W-1:0]      Fword = '0;
  logic [NCH*PH_W-1:0]   Pword = '0, Pwidth = '0;
  logic [NCH*CNT_W-1:0]  Num = '0;
  logic                  Busy, Done;
  logic [NCH-1:0]        DA_Clk;
  logic [NCH*DATA_W-1:0] DA_Data;

  dds_pulse_burst_mc dut (
    .Clk(Clk), .Rst(Rst), .EN(EN), .Stop(Stop), .Mode(Mode), .Fword(Fword),
    .Pword(Pword), .Pwidth(Pwidth), .Num(Num), .Busy(Busy), .Done(Done),
    .DA_Clk(DA_Clk), .DA_Data(DA_Data)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic                  busy;
    logic                  done;
    logic [NCH*DATA_W-1:0] da;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   r_ftop;
  bit   r_cont;
  int   r_pw[NCH], r_wid[NCH], r_num[NCH];

  // Phase position k cycles into the run; pulse index counts pulses started so far (1-based).
  function automatic bit ch_in(input int k, input int ch, output int idx);
    longint pos;
    pos = longint'(k) * r_ftop + r_pw[ch];
    idx = int'(pos / 65536) + ((r_pw[ch] < r_wid[ch]) ? 1 : 0);
    return (pos % 65536) < r_wid[ch];
  endfunction

  function automatic bit ch_hi(input int k, input int ch);
    int idx;
    bit in_b;
    if (k < 0) return 1'b0;
    in_b = ch_in(k, ch, idx);
    return in_b && (r_cont || idx <= r_num[ch]);
  endfunction

  // Run-cycle index at which the channel's last pulse ends; -1 if degenerate.
  function automatic int end_k(input int ch);
    int  i0, i1;
    bit  a, b;
    if (r_num[ch] == 0 || r_wid[ch] == 0) return -1;
    for (int k = 1; k < 2000; k++) begin
      a = ch_in(k - 1, ch, i0);
      b = ch_in(k, ch, i1);
      if (a && i0 == r_num[ch] && (!b || i1 != i0)) return k;
    end
    return NEVER;
  endfunction

  function automatic exp_t exp_at(input int j, input int kk, input int abort_at);
    exp_t e;
    e.busy = 1'b0;
    e.done = 1'b0;
    e.da   = {NCH{LO}};
    if (abort_at > 0 && j > abort_at) return e;
    e.busy = (j <= kk + 2);
    e.done = (j == kk + 3);
    for (int c = 0; c < NCH; c++)
      if (j <= kk + 2 && ch_hi(j - 2, c)) e.da[c*DATA_W +: DATA_W] = HI;
    return e;
  endfunction

  // Starts a run from a falling edge; sample j is taken j cycles after the EN edge.
  task automatic run(input string name, input bit mode, input logic [31:0] fword,
                     input int p0, input int w0, input int n0,
                     input int p1, input int w1, input int n1,
                     input int abort_at, input bit abort_rst, input bit noise, input int jmax);
    int   kk, jj;
    exp_t e;
    r_cont = mode; r_ftop = int'(fword >> 16);
    r_pw[0] = p0; r_wid[0] = w0; r_num[0] = n0;
    r_pw[1] = p1; r_wid[1] = w1; r_num[1] = n1;
    if (mode) kk = NEVER;
    else begin
      kk = end_k(0);
      if (end_k(1) > kk) kk = end_k(1);
    end
    jj = (jmax > 0) ? jmax : kk + 3;
    Mode = mode; Fword = fword;
    Pword  = {p1[15:0], p0[15:0]};
    Pwidth = {w1[15:0], w0[15:0]};
    Num    = {n1[15:0], n0[15:0]};
    EN = 1'b1;
    for (int j = 1; j <= jj; j++) begin
      sb.push_back(exp_at(j, kk, abort_at));
      @(negedge Clk);
      e = sb.pop_front();
      total++;
      if (Busy !== e.busy) begin
        bad++; $display("FAIL %s busy j=%0d got=%0b want=%0b", name, j, Busy, e.busy);
      end
      total++;
      if (Done !== e.done) begin
        bad++; $display("FAIL %s done j=%0d got=%0b want=%0b", name, j, Done, e.done);
      end
      total++;
      if (DA_Data !== e.da) begin
        bad++; $display("FAIL %s da j=%0d got=%h want=%h", name, j, DA_Data, e.da);
      end
      EN = noise && j >= 8 && j < 13;
      if (noise && j >= 8 && j < 13) begin
        Fword = $urandom; Pword = $urandom; Pwidth = $urandom; Num = $urandom;
        Mode = 1'($urandom_range(1));
      end
      if (abort_at > 0 && j == abort_at) begin
        if (abort_rst) Rst = 1'b1; else Stop = 1'b1;
      end
      if (abort_at > 0 && j == abort_at + 1) begin
        Rst = 1'b0; Stop = 1'b0;
      end
    end
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      total++;
      if (Busy !== 1'b0 || Done !== 1'b0 || DA_Data !== {NCH{LO}}) begin
        bad++; $display("FAIL %s idle busy=%0b done=%0b da=%h want 0 0 %h", name, Busy, Done, DA_Data, {NCH{LO}});
      end
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || DA_Data !== {NCH{LO}}) begin
      bad++; $display("FAIL reset busy=%0b done=%0b da=%h want 0 0 %h", Busy, Done, DA_Data, {NCH{LO}});
    end
    total++;
    if (DA_Clk !== {NCH{1'b1}}) begin
      bad++; $display("FAIL reset da_clk got=%b want=%b (Clk low)", DA_Clk, {NCH{1'b1}});
    end
    Rst = 1'b0;
    Fword = 32'h1000_0000; Pwidth = {16'h0, 16'h4000}; Num = {16'h0, 16'h3};
    EN = 1'b1; Stop = 1'b1;
    @(negedge Clk);
    total++;
    if (Busy !== 1'b0) begin
      bad++; $display("FAIL stop_beats_en busy got=%0b want=0", Busy);
    end
    EN = 1'b0; Stop = 1'b0;
    idle("after_reset", 2);
  endtask

  task automatic test_burst_single;
    run("burst_single", 1'b0, 32'h1000_0000, 0, 16'h4000, 3, 0, 16'h4000, 0, 0, 1'b0, 1'b0, 0);
    idle("burst_single", 3);
  endtask

  task automatic test_two_channel;
    run("two_channel", 1'b0, 32'h1000_0000, 0, 16'h4000, 3, 16'h8000, 16'h4000, 3, 0, 1'b0, 1'b0, 0);
    idle("two_channel", 3);
  endtask

  task automatic test_continuous_stop;
    run("continuous", 1'b1, 32'h1000_0000, 0, 16'h4000, 3, 16'h8000, 16'h4000, 0, 100, 1'b0, 1'b0, 103);
    idle("continuous", 3);
  endtask

  task automatic test_degenerate;
    run("degenerate", 1'b0, 32'h1000_0000, 0, 16'h4000, 0, 0, 0, 3, 0, 1'b0, 1'b0, 0);
    idle("degenerate", 3);
  endtask

  task automatic test_reset_mid_run;
    run("rst_mid", 1'b0, 32'h1000_0000, 0, 16'h4000, 3, 0, 16'h4000, 0, 20, 1'b1, 1'b0, 22);
    idle("rst_mid", 2);
    run("rst_restart", 1'b0, 32'h1000_0000, 0, 16'h4000, 3, 0, 16'h4000, 0, 0, 1'b0, 1'b0, 0);
    idle("rst_restart", 3);
  endtask

  task automatic test_ignore_inputs;
    run("ignore_inputs", 1'b0, 32'h1000_0000, 0, 16'h4000, 3, 0, 16'h4000, 0, 0, 1'b0, 1'b1, 0);
    idle("ignore_inputs", 3);
  endtask

  task automatic test_wrap;
    run("wrap", 1'b0, 32'h3000_0000, 0, 16'hFFFF, 2, 0, 16'h8000, 0, 0, 1'b0, 1'b0, 0);
    idle("wrap", 3);
  endtask

  task automatic test_fword_zero;
    run("fword_zero", 1'b0, 32'h0, 0, 1, 1, 16'h0010, 8, 5, 20, 1'b0, 1'b0, 23);
    idle("fword_zero", 3);
  endtask

  task automatic test_back_to_back;
    run("b2b_first", 1'b0, 32'h1000_0000, 0, 16'h4000, 0, 0, 0, 3, 0, 1'b0, 1'b0, 0);
    run("b2b_second", 1'b0, 32'h1000_0000, 0, 16'h4000, 3, 16'h8000, 16'h4000, 3, 0, 1'b0, 1'b0, 0);
    idle("b2b", 3);
  endtask

  initial begin
    test_reset;
    test_burst_single;
    test_two_channel;
    test_continuous_stop;
    test_degenerate;
    test_reset_mid_run;
    test_ignore_inputs;
    test_wrap;
    test_fword_zero;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
